// File: rtl/rca_word_sequencer.sv
// rtl/rca_word_sequencer.sv - multi-precision adder sequenced through one SIZE-bit ripple-carry chain
// Optional feature macro: RCA_SEQ_SUB_EN (adds op port; op=1 computes A - B)

// Plain SIZE-bit ripple-carry chain; the sequencer feeds it one chunk per clock.
module rca_chain #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] x,
  input  logic [SIZE-1:0] y,
  input  logic            ci,
  output logic [SIZE-1:0] s,
  output logic            co
);

  logic [SIZE:0] c;

  assign c[0] = ci;

  genvar i;
  generate
    for (i = 0; i < SIZE; i++) begin : g_fa
      assign s[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  endgenerate

  assign co = c[SIZE];

endmodule

module rca_word_sequencer #(
  parameter int SIZE  = 8,
  parameter int WORDS = 4,
  parameter int W     = SIZE * WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic         op,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout
);

  // Counter holds 0..WORDS-1 but never collapses below one bit.
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [KW-1:0] k_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          carry_q;
  logic [W-1:0]  result_q;
  logic          cout_q;

  logic          accept;
  logic          last_chunk;
  logic [SIZE-1:0] chunk_a;
  logic [SIZE-1:0] chunk_b;
  logic [SIZE-1:0] chunk_sum;
  logic            chunk_co;

  // Operand chunk k feeds the shared narrow chain.
  assign chunk_a = a_q[k_q*SIZE +: SIZE];
  assign chunk_b = b_q[k_q*SIZE +: SIZE];

  rca_chain #(.SIZE(SIZE)) u_chain (
    .x  (chunk_a),
    .y  (chunk_b),
    .ci (carry_q),
    .s  (chunk_sum),
    .co (chunk_co)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; a start in DONE restarts immediately for back-to-back use.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    last_chunk = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (k_q == KW'(WORDS - 1)) begin
          last_chunk = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture on accept, then one chunk per RUN cycle with the carry held between chunks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else if (accept) begin
      k_q      <= '0;
      a_q      <= a;
      result_q <= '0;
`ifdef RCA_SEQ_SUB_EN
      // Subtract as A + ~B + 1; the caller's cin is irrelevant in that mode.
      b_q      <= op ? ~b : b;
      carry_q  <= op ? 1'b1 : cin;
`else
      b_q      <= b;
      carry_q  <= cin;
`endif
    end else if (state_q == S_RUN) begin
      result_q[k_q*SIZE +: SIZE] <= chunk_sum;
      carry_q                    <= chunk_co;
      if (last_chunk) begin
        cout_q <= chunk_co;
        k_q    <= '0;
      end else begin
        k_q    <= k_q + 1'b1;
      end
    end
  end

  // Outputs come straight from registers; nothing combinational from the inputs.
  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_rca_word_sequencer.sv
// tb/tb_rca_word_sequencer.sv - scoreboard bench for rca_word_sequencer (SIZE=8, WORDS=4)
module tb_rca_word_sequencer;

  localparam int SIZE  = 8;
  localparam int WORDS = 4;
  localparam int W     = SIZE * WORDS;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         op;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;

  int checks;
  int errors;
  logic [W:0] exp_q[$];

  rca_word_sequencer #(.SIZE(SIZE), .WORDS(WORDS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .cin    (cin),
`ifdef RCA_SEQ_SUB_EN
    .op     (op),
`endif
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        chk("result", 64'(result), 64'(e[W-1:0]));
        chk("cout", 64'(cout), 64'(e[W]));
      end
    end
  end

  // Drive start for one edge; push the expected sum only when the bench knows it will be accepted.
  task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc,
                       input logic oo, input bit push);
    logic [W:0] e;
    start = 1'b1;
    a     = aa;
    b     = bb;
    cin   = cc;
    op    = oo;
    if (push) begin
      if (oo)
        e = {1'b0, aa} + {1'b0, ~bb} + (W+1)'(1);
      else
        e = {1'b0, aa} + {1'b0, bb} + (W+1)'(cc);
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a     = 'x;
    b     = 'x;
    cin   = 1'bx;
    op    = 1'b0;
  endtask

  // Called one negedge after the accepting edge; stops on the negedge where done is high.
  task automatic wait_done(output int lat, output int nbusy);
    lat   = 1;
    nbusy = 0;
    while (!done && lat < 30) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    lat = lat - 1;
    if (!done) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int lat;
    int nb;
    int dcount;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;
    op     = 1'b0;

    idle_cycles(3);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Simple add with latency and busy length.
    issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    chk("busy_after_start", 64'(busy), 64'd1);
    wait_done(lat, nb);
    chk("latency", 64'(lat), 64'(WORDS));
    chk("busy_cycles", 64'(nb), 64'(WORDS));
    chk("busy_in_done", 64'(busy), 64'd0);
    chk("simple_add_value", 64'(result), 64'h100);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    idle_cycles(2);
    chk("hold_result", 64'(result), 64'h100);

    // Carry through every chunk.
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    wait_done(lat, nb);
    chk("full_carry_cout", 64'(cout), 64'd1);
    idle_cycles(2);

    // Start while busy is ignored.
    issue(32'h1, 32'h2, 1'b0, 1'b0, 1'b1);
    issue(32'hAA, 32'h2, 1'b0, 1'b0, 1'b0);
    wait_done(lat, nb);
    chk("ignored_start_latency", 64'(lat), 64'(WORDS - 1));
    chk("ignored_start_value", 64'(result), 64'h3);
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("no_second_done", 64'(dcount), 64'd0);

    // Back-to-back: restart during the DONE cycle.
    issue(32'h3, 32'h4, 1'b0, 1'b0, 1'b1);
    wait_done(lat, nb);
    issue(32'h10, 32'h20, 1'b0, 1'b0, 1'b1);
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_done(lat, nb);
    chk("b2b_latency", 64'(lat), 64'(WORDS));
    chk("b2b_value", 64'(result), 64'h30);
    idle_cycles(2);

    // Reset in the middle of RUN aborts with no done.
    issue(32'h1234_5678, 32'h1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_cout", 64'(cout), 64'd0);
    idle_cycles(2);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort_no_done", 64'(dcount), 64'd0);
    issue(32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0, 1'b1);
    wait_done(lat, nb);
    chk("after_abort_value", 64'(result), 64'h0303_0303);
    idle_cycles(1);

`ifdef RCA_SEQ_SUB_EN
    issue(32'd5, 32'd7, 1'b0, 1'b1, 1'b1);
    wait_done(lat, nb);
    chk("sub_borrow", 64'(result), 64'hFFFF_FFFE);
    idle_cycles(1);
    issue(32'd7, 32'd5, 1'b1, 1'b1, 1'b1);
    wait_done(lat, nb);
    chk("sub_no_borrow", 64'(result), 64'h2);
    idle_cycles(1);
`endif

    // Random operands, alternating idle gaps and back-to-back restarts.
    for (int n = 0; n < 10; n++) begin
      issue($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      wait_done(lat, nb);
      if (n % 2 == 1) @(negedge clk);
    end
    idle_cycles(2);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
